// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-port word RAM.
// Define ARB_ROUND_ROBIN_EN to alternate grants on contention; otherwise the data port has fixed priority.
module mem_arbiter #(
   parameter int RAM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] i_address,
   input  logic        i_read,
   output logic        i_waitrequest,
   output logic [31:0] i_readdata,
   input  logic [31:0] d_address,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [3:0]  d_byteenable,
   input  logic [31:0] d_writedata,
   output logic        d_waitrequest,
   output logic [31:0] d_readdata,
   output logic [31:0] ram_address,
   output logic [3:0]  ram_byteenable,
   output logic        ram_read,
   output logic        ram_write,
   output logic [31:0] ram_writedata,
   input  logic [31:0] ram_readdata
);
   localparam int AW = $clog2(RAM_WORDS);

   typedef enum logic [1:0] {IDLE, ACCESS, DATA} state_t;
   state_t state_reg, state_next;

   logic        owner_data_reg;
   logic        write_reg;
   logic [31:0] address_reg;
   logic [3:0]  byteenable_reg;
   logic [31:0] writedata_reg;

   logic        d_req;
   logic        i_req;
   logic        grant_data;
   logic        completing;
   logic [31:0] sel_address;
   logic        unused_addr_bits;

   assign d_req = d_read | d_write;
   assign i_req = i_read;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_data_reg;

   // On contention the port that did not get the previous grant wins.
   assign grant_data = d_req && !(i_req && last_data_reg);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_data_reg <= 1'b0;
      end else if (state_reg == IDLE && (d_req || i_req)) begin
         last_data_reg <= grant_data;
      end
   end
`else
   assign grant_data = d_req;
`endif

   assign sel_address      = grant_data ? d_address : i_address;
   assign unused_addr_bits = ^{sel_address[31:AW+2], sel_address[1:0]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         owner_data_reg <= 1'b0;
         write_reg      <= 1'b0;
         address_reg    <= '0;
         byteenable_reg <= '0;
         writedata_reg  <= '0;
      end else begin
         state_reg <= state_next;
         // Operands are captured only at grant so the requester may change them mid-flight.
         if (state_reg == IDLE && (d_req || i_req)) begin
            owner_data_reg <= grant_data;
            write_reg      <= grant_data && d_write;
            address_reg    <= {{(32-AW){1'b0}}, sel_address[AW+1:2]};
            byteenable_reg <= grant_data ? d_byteenable : 4'hF;
            writedata_reg  <= grant_data ? d_writedata : 32'h0;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      ram_read   = 1'b0;
      ram_write  = 1'b0;
      completing = 1'b0;
      case (state_reg)
         IDLE: begin
            if (d_req || i_req) state_next = ACCESS;
         end
         ACCESS: begin
            ram_write  = write_reg;
            ram_read   = !write_reg;
            completing = write_reg;
            state_next = write_reg ? IDLE : DATA;
         end
         DATA: begin
            completing = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign d_waitrequest  = d_req && !(completing && owner_data_reg);
   assign i_waitrequest  = i_req && !(completing && !owner_data_reg);
   assign d_readdata     = ram_readdata;
   assign i_readdata     = ram_readdata;
   assign ram_address    = address_reg;
   assign ram_byteenable = byteenable_reg;
   assign ram_writedata  = writedata_reg;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized dual-port traffic checked
// against a transaction-level schedule and word-memory model.
module tb_mem_arbiter;
   localparam int RAM_WORDS = 4096;
   localparam int RND_WORDS = 32;

   logic        clk;
   logic        reset;
   logic [31:0] i_address;
   logic        i_read;
   logic        i_waitrequest;
   logic [31:0] i_readdata;
   logic [31:0] d_address;
   logic        d_read;
   logic        d_write;
   logic [3:0]  d_byteenable;
   logic [31:0] d_writedata;
   logic        d_waitrequest;
   logic [31:0] d_readdata;
   logic [31:0] ram_address;
   logic [3:0]  ram_byteenable;
   logic        ram_read;
   logic        ram_write;
   logic [31:0] ram_writedata;
   logic [31:0] ram_readdata;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] model_mem [0:RAM_WORDS-1];
   bit          model_last_data;

   logic [31:0] ram_mem [0:RAM_WORDS-1];
   logic        bd_we;
   logic [11:0] bd_idx;
   logic [31:0] bd_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter #(.RAM_WORDS(RAM_WORDS)) dut (
      .clk(clk), .reset(reset),
      .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
      .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_byteenable(d_byteenable),
      .d_writedata(d_writedata), .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
      .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_read(ram_read),
      .ram_write(ram_write), .ram_writedata(ram_writedata), .ram_readdata(ram_readdata)
   );

   // Bench RAM: registered read, byte-lane writes, backdoor preload port.
   always @(posedge clk) begin
      if (bd_we) begin
         ram_mem[bd_idx] <= bd_data;
      end else if (ram_write) begin
         for (int b = 0; b < 4; b++)
            if (ram_byteenable[b]) ram_mem[ram_address[11:0]][8*b +: 8] <= ram_writedata[8*b +: 8];
      end
      if (ram_read) ram_readdata <= ram_mem[ram_address[11:0]];
   end

   // Arbitration rule: lone requester wins; on contention data wins unless
   // round-robin is enabled and data had the previous grant.
   function automatic bit model_pick_data(input bit dq, input bit iq);
      if (dq && iq) begin
`ifdef ARB_ROUND_ROBIN_EN
         return !model_last_data;
`else
         return 1'b1;
`endif
      end
      return dq;
   endfunction

   task automatic clear_inputs;
      i_address = '0; i_read = 1'b0;
      d_address = '0; d_read = 1'b0; d_write = 1'b0;
      d_byteenable = '0; d_writedata = '0;
   endtask

   task automatic do_reset;
      @(negedge clk);
      clear_inputs;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_last_data = 1'b0;
   endtask

   task automatic bd_write(input int idx, input logic [31:0] v);
      @(negedge clk);
      bd_we = 1'b1; bd_idx = 12'(idx); bd_data = v;
      @(negedge clk);
      bd_we = 1'b0;
      model_mem[idx] = v;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      clear_inputs;
      @(negedge clk);
      @(negedge clk);
      #1;
      n_tests++;
      if ({ram_read, ram_write, ram_address, ram_byteenable, ram_writedata} !== 70'h0) begin
         n_fail++;
         $display("FAIL reset_ram_outputs: got rd=%b wr=%b addr=%h be=%h wd=%h want all zero",
                  ram_read, ram_write, ram_address, ram_byteenable, ram_writedata);
      end
      n_tests++;
      if ({d_waitrequest, i_waitrequest} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_waitrequest: got d=%b i=%b want 0 0", d_waitrequest, i_waitrequest);
      end
      @(negedge clk);
      reset = 1'b0;
      model_last_data = 1'b0;
      @(negedge clk);
      #1;
      n_tests++;
      if ({ram_read, ram_write} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_idle: got rd=%b wr=%b want 0 0", ram_read, ram_write);
      end
      $display("[TB] reset: outputs checked");
   endtask

   task automatic test_write_basic;
      do_reset;
      @(negedge clk);
      d_write = 1'b1; d_address = 32'h10; d_writedata = 32'h12345678; d_byteenable = 4'hF;
      #1;
      n_tests++;
      if (d_waitrequest !== 1'b1) begin
         n_fail++; $display("FAIL wr_c1_wait: got %b want 1", d_waitrequest);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if ({ram_write, ram_read, ram_address, ram_writedata, ram_byteenable, d_waitrequest} !==
          {1'b1, 1'b0, 32'h4, 32'h12345678, 4'hF, 1'b0}) begin
         n_fail++;
         $display("FAIL wr_c2_access: got wr=%b rd=%b addr=%h wd=%h be=%h wait=%b want 1 0 00000004 12345678 f 0",
                  ram_write, ram_read, ram_address, ram_writedata, ram_byteenable, d_waitrequest);
      end
      @(negedge clk);
      d_write = 1'b0;
      #1;
      n_tests++;
      if (ram_write !== 1'b0 || ram_mem[4] !== 32'h12345678) begin
         n_fail++;
         $display("FAIL wr_c3_commit: got wr=%b mem[4]=%h want 0 12345678", ram_write, ram_mem[4]);
      end
      $display("[TB] write D @00000010 data 12345678");
   endtask

   task automatic test_read_basic;
      do_reset;
      bd_write(2, 32'hDEADBEEF);
      @(negedge clk);
      i_read = 1'b1; i_address = 32'h8;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         n_tests++;
         if (i_waitrequest !== (c != 2)) begin
            n_fail++; $display("FAIL rd_wait_c%0d: got %b want %b", c + 1, i_waitrequest, c != 2);
         end
         if (c == 1) begin
            n_tests++;
            if (ram_read !== 1'b1 || ram_address !== 32'h2) begin
               n_fail++; $display("FAIL rd_access: got rd=%b addr=%h want 1 00000002", ram_read, ram_address);
            end
         end
         if (c == 2) begin
            n_tests++;
            if (i_readdata !== 32'hDEADBEEF) begin
               n_fail++; $display("FAIL rd_data: got %h want deadbeef", i_readdata);
            end
         end
      end
      i_read = 1'b0;
      $display("[TB] read I @00000008 data %h", 32'hDEADBEEF);
   endtask

   task automatic test_priority;
      do_reset;
      bd_write(3, 32'hA1A2A3A4);
      bd_write(5, 32'hB1B2B3B4);
      @(negedge clk);
      d_read = 1'b1; d_address = 32'hC; i_read = 1'b1; i_address = 32'h14;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 3) d_read = 1'b0;
         #1;
         n_tests++;
         if ({d_waitrequest, i_waitrequest} !== {c < 2, c != 5}) begin
            n_fail++;
            $display("FAIL prio_wait_c%0d: got d=%b i=%b want d=%b i=%b",
                     c + 1, d_waitrequest, i_waitrequest, c < 2, c != 5);
         end
         if (c == 2) begin
            n_tests++;
            if (d_readdata !== 32'hA1A2A3A4) begin
               n_fail++; $display("FAIL prio_d_data: got %h want a1a2a3a4", d_readdata);
            end
         end
         if (c == 5) begin
            n_tests++;
            if (i_readdata !== 32'hB1B2B3B4) begin
               n_fail++; $display("FAIL prio_i_data: got %h want b1b2b3b4", i_readdata);
            end
         end
      end
      @(negedge clk);
      clear_inputs;
      $display("[TB] contention: D done cycle 3, I done cycle 6");
   endtask

   task automatic test_continuous;
      bit win_d;
      do_reset;
      @(negedge clk);
      d_read = 1'b1; d_address = 32'h40; i_read = 1'b1; i_address = 32'h80;
      win_d = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (c % 3 == 0) begin
            win_d = model_pick_data(1'b1, 1'b1);
            model_last_data = win_d;
         end
         n_tests++;
         if (c % 3 == 2) begin
            if ({d_waitrequest, i_waitrequest} !== {!win_d, win_d}) begin
               n_fail++;
               $display("FAIL cont_grant_%0d: got d_wait=%b i_wait=%b want d_wait=%b i_wait=%b",
                        c / 3, d_waitrequest, i_waitrequest, !win_d, win_d);
            end
            $display("[TB] continuous grant %0d -> %s", c / 3, win_d ? "D" : "I");
         end else if ({d_waitrequest, i_waitrequest} !== 2'b11) begin
            n_fail++;
            $display("FAIL cont_stall_c%0d: got d=%b i=%b want 1 1", c, d_waitrequest, i_waitrequest);
         end
      end
      @(negedge clk);
      clear_inputs;
   endtask

   task automatic test_wrap;
      do_reset;
      @(negedge clk);
      d_write = 1'b1; d_address = 32'h4004; d_writedata = 32'hCAFEF00D; d_byteenable = 4'hF;
      @(negedge clk);
      #1;
      n_tests++;
      if (ram_write !== 1'b1 || ram_address !== 32'h1) begin
         n_fail++; $display("FAIL wrap_addr: got wr=%b addr=%h want 1 00000001", ram_write, ram_address);
      end
      @(negedge clk);
      clear_inputs;
      i_read = 1'b1; i_address = 32'h8004;
      @(negedge clk);
      @(negedge clk);
      #1;
      n_tests++;
      if (i_waitrequest !== 1'b0 || i_readdata !== 32'hCAFEF00D) begin
         n_fail++; $display("FAIL wrap_read: got wait=%b data=%h want 0 cafef00d", i_waitrequest, i_readdata);
      end
      @(negedge clk);
      clear_inputs;
      $display("[TB] wrap D @00004004 -> word 1");
   endtask

   task automatic test_reset_access;
      do_reset;
      bd_write(8, 32'h55AA1234);
      @(negedge clk);
      d_write = 1'b1; d_address = 32'h20; d_writedata = 32'hFFFFFFFF; d_byteenable = 4'hF;
      @(negedge clk);
      #1;
      n_tests++;
      if (ram_write !== 1'b1) begin
         n_fail++; $display("FAIL rst_acc_pre: got wr=%b want 1", ram_write);
      end
      reset = 1'b1;
      #1;
      n_tests++;
      if ({ram_write, ram_read, ram_address, d_waitrequest} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
         n_fail++;
         $display("FAIL rst_acc_drop: got wr=%b rd=%b addr=%h wait=%b want 0 0 00000000 1",
                  ram_write, ram_read, ram_address, d_waitrequest);
      end
      clear_inputs;
      @(negedge clk);
      reset = 1'b0;
      model_last_data = 1'b0;
      @(negedge clk);
      #1;
      n_tests++;
      if (ram_mem[8] !== 32'h55AA1234 || {ram_read, ram_write} !== 2'b00) begin
         n_fail++;
         $display("FAIL rst_acc_mem: got mem[8]=%h rd=%b wr=%b want 55aa1234 0 0", ram_mem[8], ram_read, ram_write);
      end
      d_read = 1'b1; d_address = 32'h20;
      @(negedge clk);
      @(negedge clk);
      #1;
      n_tests++;
      if (d_waitrequest !== 1'b0 || d_readdata !== 32'h55AA1234) begin
         n_fail++;
         $display("FAIL rst_acc_reread: got wait=%b data=%h want 0 55aa1234", d_waitrequest, d_readdata);
      end
      @(negedge clk);
      clear_inputs;
      $display("[TB] reset during write ACCESS @00000020 abandoned");
   endtask

   task automatic test_random(input int n_txn);
      int          dsel, idx_d, idx_i, d_done, i_done, d_acc, i_acc, last;
      bit          dq, iq, d_wr, win_d;
      logic [31:0] da, ia, dwd, exp_d, exp_i;
      logic [3:0]  dbe;
      do_reset;
      for (int w = 0; w < RND_WORDS; w++) bd_write(w, $urandom);
      for (int t = 0; t < n_txn; t++) begin
         dsel = $urandom_range(0, 3);
         dq   = (dsel != 0);
         d_wr = (dsel >= 2);
         iq   = ($urandom_range(0, 1) == 1) || !dq;
         da   = (($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFF_C000) : 32'h0) |
                (32'($urandom_range(0, RND_WORDS - 1)) << 2) | ($urandom & 32'h3);
         ia   = (($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFF_C000) : 32'h0) |
                (32'($urandom_range(0, RND_WORDS - 1)) << 2) | ($urandom & 32'h3);
         dwd  = $urandom;
         dbe  = 4'($urandom);
         idx_d = int'((da >> 2) % RAM_WORDS);
         idx_i = int'((ia >> 2) % RAM_WORDS);

         // Schedule: winner completes 1 (write) or 2 (read) cycles after grant;
         // loser is granted in the IDLE cycle right after the winner completes.
         win_d = model_pick_data(dq, iq);
         model_last_data = win_d;
         d_done = -10; i_done = -10; d_acc = -10; i_acc = -10;
         if (win_d) begin
            d_acc  = 1;
            d_done = d_wr ? 1 : 2;
            if (iq) begin
               i_acc = d_done + 2; i_done = i_acc + 1; model_last_data = 1'b0;
            end
         end else begin
            i_acc = 1; i_done = 2;
            if (dq) begin
               d_acc = i_done + 2; d_done = d_wr ? d_acc : d_acc + 1; model_last_data = 1'b1;
            end
         end
         if (dq && d_wr && win_d)
            for (int b = 0; b < 4; b++) if (dbe[b]) model_mem[idx_d][8*b +: 8] = dwd[8*b +: 8];
         exp_i = model_mem[idx_i];
         if (dq && d_wr && !win_d)
            for (int b = 0; b < 4; b++) if (dbe[b]) model_mem[idx_d][8*b +: 8] = dwd[8*b +: 8];
         exp_d = model_mem[idx_d];
         last = (d_done > i_done) ? d_done : i_done;
         $display("[TB] txn %0d: D=%s @%h I=%s @%h first=%s", t,
                  !dq ? "--" : (d_wr ? "WR" : "RD"), da, iq ? "RD" : "--", ia, win_d ? "D" : "I");

         @(negedge clk);
         d_read = (dsel % 2 == 1); d_write = d_wr; d_address = da; d_writedata = dwd; d_byteenable = dbe;
         i_read = iq; i_address = ia;
         for (int c = 0; c <= last; c++) begin
            if (c > 0) begin
               @(negedge clk);
               if (c == d_done + 1) begin d_read = 1'b0; d_write = 1'b0; end
               if (c == i_done + 1) i_read = 1'b0;
               if (c == 1) begin
                  if (win_d) begin
                     d_address = $urandom; d_writedata = $urandom; d_byteenable = 4'($urandom);
                  end else begin
                     i_address = $urandom;
                  end
               end
            end
            #1;
            n_tests++;
            if ({d_waitrequest, i_waitrequest, ram_write, ram_read} !==
                {dq && c < d_done, iq && c < i_done, c == d_acc && d_wr, (c == d_acc && !d_wr) || c == i_acc}) begin
               n_fail++;
               $display("FAIL rnd_ctrl t%0d c%0d: got dw=%b iw=%b wr=%b rd=%b want dw=%b iw=%b wr=%b rd=%b",
                        t, c, d_waitrequest, i_waitrequest, ram_write, ram_read, dq && c < d_done,
                        iq && c < i_done, c == d_acc && d_wr, (c == d_acc && !d_wr) || c == i_acc);
            end
            if (c == d_acc || c == i_acc) begin
               n_tests++;
               if (ram_address !== 32'((c == d_acc) ? idx_d : idx_i)) begin
                  n_fail++;
                  $display("FAIL rnd_addr t%0d c%0d: got %h want %h", t, c, ram_address,
                           32'((c == d_acc) ? idx_d : idx_i));
               end
            end
            if (c == d_acc && d_wr) begin
               n_tests++;
               if (ram_writedata !== dwd || ram_byteenable !== dbe) begin
                  n_fail++;
                  $display("FAIL rnd_wdata t%0d: got %h/%h want %h/%h", t, ram_writedata, ram_byteenable, dwd, dbe);
               end
            end
            if (c == d_done && !d_wr) begin
               n_tests++;
               if (d_readdata !== exp_d) begin
                  n_fail++; $display("FAIL rnd_d_data t%0d: got %h want %h", t, d_readdata, exp_d);
               end
            end
            if (c == i_done) begin
               n_tests++;
               if (i_readdata !== exp_i) begin
                  n_fail++; $display("FAIL rnd_i_data t%0d: got %h want %h", t, i_readdata, exp_i);
               end
            end
         end
         @(negedge clk);
         clear_inputs;
      end
   endtask

   initial begin
      bd_we = 1'b0; bd_idx = '0; bd_data = '0;
      model_last_data = 1'b0;
      test_reset;
      test_write_basic;
      test_read_basic;
      test_priority;
      test_continuous;
      test_wrap;
      test_reset_access;
      test_random(80);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 4096, meaning the RAM depth in words; it SHALL be a power of two.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 i_address  in  32  instruction-fetch byte address.
REQ-005 i_read  in  1  instruction-fetch read request.
REQ-006 i_waitrequest  out  1  instruction port stall.
REQ-007 i_readdata  out  32  instruction read data.
REQ-008 d_address  in  32  data-port byte address.
REQ-009 d_read  in  1  data read request.
REQ-010 d_write  in  1  data write request.
REQ-011 d_byteenable  in  4  data write byte lanes, passed through.
REQ-012 d_writedata  in  32  data write value.
REQ-013 d_waitrequest  out  1  data port stall.
REQ-014 d_readdata  out  32  data read data.
REQ-015 ram_address  out  32  RAM word address.
REQ-016 ram_byteenable / ram_read / ram_write  out  4/1/1  RAM controls.
REQ-017 ram_writedata  out  32  RAM write value.
REQ-018 ram_readdata  in  32  RAM read data, valid one cycle after a ram_read cycle.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, DATA.
REQ-020 IDLE: when any request is high, pick a winner (REQ-027), register owner, command and operands, then go to ACCESS; with no request, stay in IDLE.
REQ-021 ram_address SHALL be registered as address[31:2] modulo RAM_WORDS, upper bits zero; address[1:0] ignored; addresses beyond RAM_WORDS wrap.
REQ-022 ACCESS: exactly one of ram_read/ram_write high for exactly this one cycle; ram_address/byteenable/writedata stable throughout.
REQ-023 Write: completes in ACCESS; next state IDLE; 2-cycle latency from request seen in IDLE.
REQ-024 Read: ACCESS -> DATA; in DATA, owner readdata = ram_readdata, completion; next state IDLE; 3-cycle latency.
REQ-025 Completion cycle: owner's waitrequest low; the requester SHALL treat request && !waitrequest at a rising edge as done.
REQ-026 x_waitrequest = (x request high) && !(x completing this cycle); low when that port has no request.
REQ-027 Winner: data port over instruction port (fixed priority) unless ARB_ROUND_ROBIN_EN.
REQ-028 d_read && d_write together: treated as write; read ignored.
REQ-029 Requester inputs are sampled only in IDLE; changes during ACCESS/DATA SHALL NOT alter the transaction in flight.
REQ-030 i_readdata and d_readdata SHALL both be driven from ram_readdata at all times; contents meaningful only at completion.
REQ-031 Loser keeps waitrequest high and is re-arbitrated in the next IDLE cycle.

Reset
REQ-032 On reset: state IDLE, ram_read=0, ram_write=0, ram_address=0, ram_byteenable=0, ram_writedata=0, round-robin flag = instruction-last.
REQ-033 Reset asserted in ACCESS SHALL deassert ram_write immediately, so no write is committed; in-flight transaction abandoned without completion.

Configuration
REQ-034 ARB_ROUND_ROBIN_EN defined: a register records the last granted port; on simultaneous requests the other port wins; single request always wins.
REQ-035 ARB_ROUND_ROBIN_EN undefined: fixed priority per REQ-027, no last-grant register.

Verification
REQ-036 Data write 0x12345678 to byte addr 0x10 -> ram_write high one cycle with ram_address 0x4; d_waitrequest low in cycle 2.
REQ-037 i_read at addr 0x8 with RAM word 2 = 0xDEADBEEF -> i_readdata 0xDEADBEEF, i_waitrequest low in cycle 3 only.
REQ-038 i_read and d_read same cycle, fixed priority -> data served first (cycle 3); instruction completes at cycle 6.
REQ-039 With ARB_ROUND_ROBIN_EN, both ports requesting continuously for 12 cycles -> grants alternate D,I,D,I.
REQ-040 reset pulsed during ACCESS of write to addr 0x20 -> ram_write drops at once; RAM word 8 unchanged; state IDLE.
REQ-041 d_address 0x4004 with RAM_WORDS 4096 -> ram_address 0x001 (wrap).
